mem_initiator: RTL and testbench
================================

# mem_initiator

Load/store initiator that drives the single-port, one-cycle-latency 32x2048 data RAM interface (`address`, `write`, `read`, `writedata` / `readdata`) on behalf of the CPU memory stage. It accepts one byte-addressed request at a time over a valid/ready handshake and converts it to word-addressed RAM accesses. Sub-word loads are extracted and sign- or zero-extended; sub-word stores use read-modify-write. Each request produces one registered response pulse.

## Interface
- `ADDR_W`, 32: byte-address width; the RAM word address is `req_addr[ADDR_W-1:2]`, zero-extended to 32 bits.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; the request is accepted on the edge where `req_valid && req_ready`.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_signed` in 1: sign-extend sub-word loads; ignored for stores and word loads.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, right-aligned in the low bits for byte and half.
- `resp_valid` out 1: one-cycle completion pulse; there is no backpressure on the response.
- `resp_rdata` out 32: load result; 0 for stores and errors.
- `resp_err` out 1: misaligned or illegal request; valid with `resp_valid`.
- `mem_address` out 32: RAM word address.
- `mem_write` out 1: RAM write strobe.
- `mem_read` out 1: RAM read strobe.
- `mem_writedata` out 32: RAM write data.
- `mem_readdata` in 32: RAM read data, valid the cycle after `mem_read`.

## Operation
- **Byte order:** big-endian, matching MIPS.
  - Byte lane for `addr[1:0]` 00/01/10/11 is bits [31:24]/[23:16]/[15:8]/[7:0].
  - Half lane for `addr[1]` 0/1 is bits [31:16]/[15:0].
- **States:** IDLE, RD_ISSUE, RD_CAPT, WR_ISSUE, RMW_RD, RMW_CAPT, RMW_WR, RESP.
- **Accept:** the request is registered on the accept edge. Next state:
  - error (half with `addr[0]`=1, word with `addr[1:0]`!=0, or size 11): RESP with `resp_err`=1; no RAM access.
  - load: RD_ISSUE.
  - word store: WR_ISSUE.
  - byte or half store: RMW_RD.
- **RD_ISSUE / RMW_RD:** `mem_read`=1 and `mem_address` driven for exactly one cycle.
- **RD_CAPT:** registers the extracted, extended lane of `mem_readdata` into `resp_rdata`, then goes to RESP.
- **RMW_CAPT:** registers `mem_readdata` with the addressed lane replaced by the low byte or half of the stored `req_wdata`, then goes to RMW_WR.
- **WR_ISSUE / RMW_WR:** `mem_write`=1 with `mem_writedata` for exactly one cycle, then RESP.
- **RESP:** `resp_valid`=1 for one cycle, then IDLE.
- **Idle strobes:** outside issue states, `mem_read`=`mem_write`=0 and `mem_address`=`mem_writedata`=0.
- **Strobe gating:** `mem_write` and `mem_read` are forced to 0 in any cycle where `reset` is high.
- **Reset values:** state IDLE; `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, all `mem_*` outputs 0. `req_ready`=1 from the first cycle after reset deasserts.
- **Reset mid-operation:** the request is aborted; no write issues, no response is produced, and no partial RMW write occurs.
- **Requests during reset or non-IDLE:** not accepted; the requester holds them.

## Timing
Cycle 0 is the accept cycle.
- **Error:** `resp_valid` in cycle 1.
- **Word store:** `mem_write` in cycle 1; `resp_valid` in cycle 2.
- **Load:** `mem_read` in cycle 1; `mem_readdata` captured at the end of cycle 2; `resp_valid` and `resp_rdata` in cycle 3.
- **Sub-word store:** `mem_read` in cycle 1, merge in cycle 2, `mem_write` in cycle 3; `resp_valid` in cycle 4.
- **Throughput:** the next accept is possible in the cycle after RESP.
- **Response outputs:** registered; they hold their values between pulses and are cleared to 0 when the next request is accepted.

## Structure
- **`mem_if_pkg`:**
  - `mem_size_t` enum (BYTE, HALF, WORD, ILLEGAL).
  - `mem_state_t` enum.
  - lane-position constants.
- **`mem_lane_unit`** (combinational sub-module):
  - `extract(data, addr[1:0], size, signed)` returns the load result.
  - `merge(old, new, addr[1:0], size)` returns the store word.
  - Instantiated once; inputs muxed by state.

## Test plan
- **Word store then load:** SW 0x00000010 ← 0xDEADBEEF, then LW 0x10.
  - Store: `mem_address`=4 with `mem_write`=1 in cycle 1 only; `resp_valid` in cycle 2.
  - Load: `resp_rdata`=0xDEADBEEF in cycle 3.
- **Byte load extension:** word 4 preloaded with 0x1280FF34.
  - LB 0x11 signed → 0xFFFFFF80.
  - LBU 0x11 → 0x00000080.
  - LH 0x12 signed → 0xFFFFFF34.
- **Byte store RMW:** SB 0x12 ← 0x000000AB onto 0xDEADBEEF.
  - One `mem_read` in cycle 1; one `mem_write` of 0xDEADABEF in cycle 3; `resp_valid` in cycle 4.
  - Memory then reads back 0xDEADABEF.
- **Misaligned:** LW 0x6, SH 0x3, size 11.
  - Each → `resp_err`=1 and `resp_rdata`=0 in cycle 1.
  - Zero `mem_read` / `mem_write` pulses.
- **Reset mid-RMW:** SB issued, `reset` asserted in the RMW_WR cycle.
  - `mem_write` stays 0 and no `resp_valid`.
  - `req_ready`=1 the cycle after reset drops; the word is unchanged.
- **Back-to-back:** `req_valid` held high across three LWs.
  - Each accepted only in IDLE; responses 4 cycles apart.
  - `req_ready` is 0 from RD_ISSUE through RESP.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared types for the load/store initiator: access sizes, FSM states and
// big-endian lane positions used to locate bytes and halves inside a RAM word.
package mem_if_pkg;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } mem_size_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPT,
    WR_ISSUE,
    RMW_RD,
    RMW_CAPT,
    RMW_WR,
    RESP
  } mem_state_t;

  // Big-endian: the lowest byte address sits in the most significant lane.
  localparam logic [4:0] BYTE0_SHIFT = 5'd24;
  localparam logic [4:0] BYTE1_SHIFT = 5'd16;
  localparam logic [4:0] BYTE2_SHIFT = 5'd8;
  localparam logic [4:0] BYTE3_SHIFT = 5'd0;
  localparam logic [4:0] HALF0_SHIFT = 5'd16;
  localparam logic [4:0] HALF1_SHIFT = 5'd0;

  localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
  localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

  function automatic logic [4:0] lane_shift(input logic [1:0] addr_lo, input mem_size_t size);
    logic [4:0] sh;
    sh = 5'd0;
    case (size)
      BYTE: begin
        case (addr_lo)
          2'b00:   sh = BYTE0_SHIFT;
          2'b01:   sh = BYTE1_SHIFT;
          2'b10:   sh = BYTE2_SHIFT;
          default: sh = BYTE3_SHIFT;
        endcase
      end
      HALF:    sh = addr_lo[1] ? HALF1_SHIFT : HALF0_SHIFT;
      default: sh = 5'd0;
    endcase
    return sh;
  endfunction

  function automatic logic req_is_bad(input logic [1:0] addr_lo, input mem_size_t size);
    logic bad;
    case (size)
      BYTE:    bad = 1'b0;
      HALF:    bad = addr_lo[0];
      WORD:    bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_initiator_if.sv
// Request/response port of the CPU memory stage plus the single-port RAM bus.
// master = the initiator, slave = the CPU side and RAM together.
interface mem_initiator_if #(
  parameter int ADDR_W = 32
);
  // Request handshake: a request transfers on the rising edge where
  // req_valid && req_ready; the requester holds all req_* fields stable until
  // then. The response has no backpressure: resp_valid is a one-cycle pulse.
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  logic [31:0]       mem_address;
  logic              mem_write;
  logic              mem_read;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata;

  modport master (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  mem_readdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_address, mem_write, mem_read, mem_writedata
  );

  modport slave (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output mem_readdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_address, mem_write, mem_read, mem_writedata
  );

endinterface

// File: rtl/mem_lane_unit.sv
// Combinational lane logic: extracts and extends a load lane from a RAM word,
// and merges a right-aligned byte/half into a RAM word for read-modify-write.
module mem_lane_unit
  import mem_if_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [31:0] new_i,
  input  logic [1:0]  addr_lo_i,
  input  mem_size_t   size_i,
  input  logic        signed_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [4:0]  shift;
  logic [31:0] lane_data;
  logic [31:0] lane_mask;

  assign shift     = lane_shift(addr_lo_i, size_i);
  assign lane_data = data_i >> shift;

  always_comb begin
    load_o    = data_i;
    lane_mask = 32'hFFFF_FFFF;
    case (size_i)
      BYTE: begin
        load_o    = {{24{signed_i & lane_data[7]}}, lane_data[7:0]};
        lane_mask = BYTE_MASK << shift;
      end
      HALF: begin
        load_o    = {{16{signed_i & lane_data[15]}}, lane_data[15:0]};
        lane_mask = HALF_MASK << shift;
      end
      default: begin
        load_o    = data_i;
        lane_mask = 32'hFFFF_FFFF;
      end
    endcase
  end

  // Shifting new_i places its low byte/half on the lane; the mask drops the rest.
  assign merge_o = (data_i & ~lane_mask) | ((new_i << shift) & lane_mask);

endmodule

// File: rtl/mem_initiator.sv
// Load/store initiator: turns one byte-addressed request at a time into
// word-addressed accesses on a one-cycle-latency single-port RAM.
module mem_initiator
  import mem_if_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  mem_initiator_if.master   bus,
  output mem_state_t        dbg_state_o
);

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  mem_size_t         size_q;
  logic              signed_q;
  logic [31:0]       wdata_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [31:0]       resp_rdata_q;

  logic              accept;
  logic              req_bad;
  mem_size_t         req_size;
  logic              rd_strobe;
  logic              wr_strobe;
  logic              issue;
  logic [31:0]       lane_data_in;
  logic [31:0]       lane_load;
  logic [31:0]       lane_merge;

  assign req_size = mem_size_t'(bus.req_size);
  assign req_bad  = req_is_bad(bus.req_addr[1:0], req_size);
  assign accept   = bus.req_valid && bus.req_ready;

  always_comb begin
    state_d   = state_q;
    rd_strobe = 1'b0;
    wr_strobe = 1'b0;
    issue     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_bad)                state_d = RESP;
          else if (!bus.req_write)    state_d = RD_ISSUE;
          else if (req_size == WORD)  state_d = WR_ISSUE;
          else                        state_d = RMW_RD;
        end
      end
      RD_ISSUE: begin
        rd_strobe = 1'b1;
        issue     = 1'b1;
        state_d   = RD_CAPT;
      end
      RD_CAPT:  state_d = RESP;
      WR_ISSUE: begin
        wr_strobe = 1'b1;
        issue     = 1'b1;
        state_d   = RESP;
      end
      RMW_RD: begin
        rd_strobe = 1'b1;
        issue     = 1'b1;
        state_d   = RMW_CAPT;
      end
      RMW_CAPT: state_d = RMW_WR;
      RMW_WR: begin
        wr_strobe = 1'b1;
        issue     = 1'b1;
        state_d   = RESP;
      end
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Read data is only meaningful in the two capture states.
  assign lane_data_in = (state_q == RD_CAPT || state_q == RMW_CAPT) ? bus.mem_readdata : 32'd0;

  mem_lane_unit u_lane (
    .data_i    (lane_data_in),
    .new_i     (wdata_q),
    .addr_lo_i (addr_q[1:0]),
    .size_i    (size_q),
    .signed_i  (signed_q),
    .load_o    (lane_load),
    .merge_o   (lane_merge)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      size_q       <= BYTE;
      signed_q     <= 1'b0;
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= (state_d == RESP);
      if (accept) begin
        addr_q       <= bus.req_addr;
        size_q       <= req_size;
        signed_q     <= bus.req_signed;
        wdata_q      <= bus.req_wdata;
        resp_err_q   <= req_bad;
        resp_rdata_q <= 32'd0;
      end
      if (state_q == RD_CAPT)  resp_rdata_q <= lane_load;
      if (state_q == RMW_CAPT) wdata_q      <= lane_merge;
    end
  end

  // Strobes are gated by reset directly so an in-flight RMW write never lands.
  assign bus.req_ready     = (state_q == IDLE) && !reset;
  assign bus.mem_read      = rd_strobe && !reset;
  assign bus.mem_write     = wr_strobe && !reset;
  assign bus.mem_address   = issue ? 32'(addr_q[ADDR_W-1:2]) : 32'd0;
  assign bus.mem_writedata = wr_strobe ? wdata_q : 32'd0;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_err      = resp_err_q;
  assign bus.resp_rdata    = resp_rdata_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed and randomized bench for mem_initiator against a byte-lane RAM model.
module tb_mem_initiator;
  import mem_if_pkg::*;

  logic       clk;
  logic       reset;
  mem_state_t dbg_state;
  int         checks;
  int         errors;

  logic [31:0] ram     [2048];
  logic [31:0] ref_mem [2048];

  mem_initiator_if #(.ADDR_W(32)) bus ();

  mem_initiator #(.ADDR_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.master),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_write) ram[bus.mem_address[10:0]] <= bus.mem_writedata;
    if (bus.mem_read)  bus.mem_readdata <= ram[bus.mem_address[10:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] sz, input logic sg);
    logic [7:0]  b [4];
    logic [15:0] h;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) b[i] = word[31-8*i -: 8];
    h = {b[{off[1], 1'b0}], b[{off[1], 1'b1}]};
    case (sz)
      2'd0:    r = (sg && b[off][7]) ? {24'hFFFFFF, b[off]} : {24'h0, b[off]};
      2'd1:    r = (sg && h[15]) ? {16'hFFFF, h} : {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] sz, input logic [31:0] wd);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = word[31-8*i -: 8];
    case (sz)
      2'd0: b[off] = wd[7:0];
      2'd1: begin
        b[{off[1], 1'b0}] = wd[15:8];
        b[{off[1], 1'b1}] = wd[7:0];
      end
      default: return wd;
    endcase
    return {b[0], b[1], b[2], b[3]};
  endfunction

  // One request: drive, watch up to 8 cycles after accept, compare with the model.
  task automatic run_req(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    int rd_n, wr_n, rd_cyc, wr_cyc, resp_cyc, exp_lat;
    logic [31:0] wr_addr, wr_data, rdata, word, exp_rdata;
    logic err, busy_ready, idle_addr_bad, bad, exp_rd, exp_wr;
    rd_n = 0; wr_n = 0; rd_cyc = 0; wr_cyc = 0; resp_cyc = 0;
    wr_addr = 0; wr_data = 0; rdata = 0; err = 0; busy_ready = 0; idle_addr_bad = 0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    check({tag, "/ready_idle"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 8 && resp_cyc == 0; c++) begin
      @(negedge clk);
      if (bus.mem_read) begin rd_n++; rd_cyc = c; end
      if (bus.mem_write) begin
        wr_n++; wr_cyc = c; wr_addr = bus.mem_address; wr_data = bus.mem_writedata;
      end
      if (!bus.mem_read && !bus.mem_write && bus.mem_address != 0) idle_addr_bad = 1'b1;
      if (bus.req_ready) busy_ready = 1'b1;
      if (bus.resp_valid) begin resp_cyc = c; rdata = bus.resp_rdata; err = bus.resp_err; end
    end
    bad     = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    word    = ref_mem[a[12:2]];
    exp_rd  = !bad && !(w && sz == 2'd2);
    exp_wr  = !bad && w;
    exp_lat = bad ? 1 : (!w ? 3 : (sz == 2'd2 ? 2 : 4));
    exp_rdata = (bad || w) ? 32'd0 : model_load(word, a[1:0], sz, sg);
    check({tag, "/resp_cycle"}, 32'(resp_cyc), 32'(exp_lat));
    check({tag, "/resp_err"}, 32'(err), 32'(bad));
    check({tag, "/resp_rdata"}, rdata, exp_rdata);
    check({tag, "/read_count"}, 32'(rd_n), 32'(exp_rd));
    check({tag, "/write_count"}, 32'(wr_n), 32'(exp_wr));
    check({tag, "/ready_busy"}, 32'(busy_ready), 32'd0);
    check({tag, "/idle_addr"}, 32'(idle_addr_bad), 32'd0);
    if (exp_rd) check({tag, "/read_cycle"}, 32'(rd_cyc), 32'd1);
    if (exp_wr) begin
      check({tag, "/write_cycle"}, 32'(wr_cyc), 32'(exp_lat - 1));
      check({tag, "/write_addr"}, wr_addr, {2'b00, a[31:2]});
      check({tag, "/write_data"}, wr_data, model_store(word, a[1:0], sz, wd));
      ref_mem[a[12:2]] = model_store(word, a[1:0], sz, wd);
    end
  endtask

  initial begin
    logic [31:0] b2b_addr [3];
    int idx;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 2048; i++) begin
      ram[i]     = 32'd0;
      ref_mem[i] = 32'd0;
    end
    bus.mem_readdata = 32'd0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    reset = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst/mem_read", 32'(bus.mem_read), 32'd0);
    check("rst/mem_write", 32'(bus.mem_write), 32'd0);
    check("rst/mem_address", bus.mem_address, 32'd0);
    check("rst/mem_writedata", bus.mem_writedata, 32'd0);
    check("rst/resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst/resp_err", 32'(bus.resp_err), 32'd0);
    check("rst/resp_rdata", bus.resp_rdata, 32'd0);
    check("rst/state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst/ready_after", 32'(bus.req_ready), 32'd1);

    // Word store/load, extension, byte RMW
    run_req("sw_10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    run_req("lw_10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    check("lw_10/model", ref_mem[4], 32'hDEADBEEF);
    run_req("sw_pre", 1'b1, 2'd2, 1'b0, 32'h10, 32'h1280FF34);
    run_req("lb_11", 1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
    run_req("lbu_11", 1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
    run_req("lh_12", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
    check("lh_12/expect", model_load(32'h1280FF34, 2'd2, 2'd1, 1'b1), 32'hFFFFFF34);
    run_req("sw_rst", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    run_req("sb_12", 1'b1, 2'd0, 1'b0, 32'h12, 32'h000000AB);
    check("sb_12/model", ref_mem[4], 32'hDEADABEF);
    run_req("lw_rb", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

    // Error cases
    run_req("lw_6", 1'b0, 2'd2, 1'b0, 32'h6, 32'h0);
    run_req("sh_3", 1'b1, 2'd1, 1'b0, 32'h3, 32'h1234);
    run_req("sz_11", 1'b0, 2'd3, 1'b0, 32'h10, 32'h0);

    // Reset during the RMW write cycle
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = 32'h12; bus.req_wdata = 32'h55;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rmw_rst/mem_write", 32'(bus.mem_write), 32'd0);
    check("rmw_rst/resp_valid", 32'(bus.resp_valid), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rmw_rst/ready", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("rmw_rst/no_resp", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
    end
    run_req("rmw_rst_lw", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

    // Back-to-back loads with req_valid held high
    b2b_addr[0] = 32'h10; b2b_addr[1] = 32'h20; b2b_addr[2] = 32'h30;
    run_req("b2b_sw20", 1'b1, 2'd2, 1'b0, 32'h20, $urandom);
    run_req("b2b_sw30", 1'b1, 2'd2, 1'b0, 32'h30, $urandom);
    idx = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'd2;
    bus.req_signed = 1'b0; bus.req_addr = b2b_addr[0];
    for (int t = 0; t < 12; t++) begin
      if (t > 0) @(negedge clk);
      check("b2b/ready", 32'(bus.req_ready), 32'((t % 4) == 0));
      check("b2b/resp_valid", 32'(bus.resp_valid), 32'((t % 4) == 3));
      if ((t % 4) == 3) check("b2b/rdata", bus.resp_rdata, ref_mem[b2b_addr[t / 4][12:2]]);
      @(posedge clk);
      #1;
      if ((t % 4) == 0) begin
        idx++;
        if (idx < 3) bus.req_addr = b2b_addr[idx];
        else bus.req_valid = 1'b0;
      end
    end

    // Randomized mix over a small window so loads hit earlier stores
    for (int n = 0; n < 60; n++) begin
      run_req("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
